// File: rtl/planificador_pid_mac_pkg.sv
// Shared Q-format defaults and FSM state encodings for the PID step sequencer.
package planificador_pid_mac_pkg;

   localparam int N_DEF = 16;
   localparam int F_DEF = 8;

   localparam logic [2:0] S_REPOSO = 3'd0;
   localparam logic [2:0] S_CARGA  = 3'd1;
   localparam logic [2:0] S_MP     = 3'd2;
   localparam logic [2:0] S_MI     = 3'd3;
   localparam logic [2:0] S_MD     = 3'd4;
   localparam logic [2:0] S_ACUM   = 3'd5;
   localparam logic [2:0] S_LISTO  = 3'd6;

   typedef enum logic [2:0] {
      REPOSO = S_REPOSO,
      CARGA  = S_CARGA,
      MP     = S_MP,
      MI     = S_MI,
      MD     = S_MD,
      ACUM   = S_ACUM,
      LISTO  = S_LISTO
   } estado_t;

endpackage

// File: rtl/planificador_pid_mac_multiplicador_reg.sv
// N x N signed multiplier with a registered full-precision 2N-bit product.
module multiplicador_reg #(
   parameter int N = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic signed [N-1:0]   a,
   input  logic signed [N-1:0]   b,
   output logic signed [2*N-1:0] p
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)  p <= '0;
      else if (en) p <= a * b;
   end

endmodule

// File: rtl/planificador_pid_mac.sv
// One PID control step per sample, sharing a single registered multiplier
// across the kp, ki and kd products; integrator and previous error live here.
module planificador_pid_mac
   import planificador_pid_mac_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int F = F_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                datolisto,
   input  logic signed [N-1:0] yk,
   input  logic signed [N-1:0] referencia,
   input  logic signed [N-1:0] kp,
   input  logic signed [N-1:0] ki,
   input  logic signed [N-1:0] kd,
   input  logic                limpiar,
   output logic signed [N-1:0] resultado,
   output logic                listo,
   output logic                ocupado,
   output logic                sobrecarga
);

   localparam logic signed [N+2:0]   HI_N = {4'b0000, {(N-1){1'b1}}};
   localparam logic signed [N+2:0]   LO_N = {4'b1111, {(N-1){1'b0}}};
   localparam logic signed [2*N-1:0] HI_W = {{(N-1){1'b0}}, {(N+1){1'b1}}};
   localparam logic signed [2*N-1:0] LO_W = {{(N-1){1'b1}}, {(N+1){1'b0}}};

   estado_t estado, estado_sig;

   logic signed [N-1:0]   yk_r, ref_r, kp_r, ki_r, kd_r;
   logic signed [N-1:0]   e, i_new, d, i_acc, e_prev;
   logic signed [N+1:0]   acc;
   logic signed [2*N-1:0] prod, prod_sh;
   logic signed [N+1:0]   prod_sat;
   logic signed [N-1:0]   e_sat, i_sat, d_sat, res_sat;
   logic signed [N-1:0]   mul_a, mul_b;
   logic                  mul_en;

   function automatic logic signed [N+2:0] sx(input logic signed [N-1:0] v);
      return {{3{v[N-1]}}, v};
   endfunction

   // Clamp any intermediate (sums, differences, accumulator) to the N-bit range.
   function automatic logic signed [N-1:0] sat_n(input logic signed [N+2:0] x);
      if (x > HI_N)      return HI_N[N-1:0];
      else if (x < LO_N) return LO_N[N-1:0];
      else               return x[N-1:0];
   endfunction

   function automatic logic signed [N+1:0] sat_w(input logic signed [2*N-1:0] x);
      if (x > HI_W)      return HI_W[N+1:0];
      else if (x < LO_W) return LO_W[N+1:0];
      else               return x[N+1:0];
   endfunction

   assign e_sat    = sat_n(sx(ref_r) - sx(yk_r));
   assign i_sat    = sat_n(sx(i_acc) + sx(e_sat));
   assign d_sat    = sat_n(sx(e_sat) - sx(e_prev));
   assign res_sat  = sat_n({acc[N+1], acc});
   assign prod_sh  = prod >>> F;
   assign prod_sat = sat_w(prod_sh);

   multiplicador_reg #(.N(N)) u_mul (
      .clk   (clk),
      .reset (reset),
      .en    (mul_en),
      .a     (mul_a),
      .b     (mul_b),
      .p     (prod)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) estado <= REPOSO;
      else        estado <= estado_sig;
   end

   always_comb begin
      estado_sig = REPOSO;
      case (estado)
         REPOSO:  estado_sig = datolisto ? CARGA : REPOSO;
         CARGA:   estado_sig = MP;
         MP:      estado_sig = MI;
         MI:      estado_sig = MD;
         MD:      estado_sig = ACUM;
         ACUM:    estado_sig = LISTO;
         default: estado_sig = REPOSO;
      endcase
   end

   // Operand mux: exactly one product issued in each of MP, MI, MD.
   always_comb begin
      ocupado = (estado != REPOSO);
      mul_en  = 1'b0;
      mul_a   = '0;
      mul_b   = '0;
      case (estado)
         MP: begin mul_en = 1'b1; mul_a = kp_r; mul_b = e;     end
         MI: begin mul_en = 1'b1; mul_a = ki_r; mul_b = i_new; end
         MD: begin mul_en = 1'b1; mul_a = kd_r; mul_b = d;     end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         yk_r       <= '0;
         ref_r      <= '0;
         kp_r       <= '0;
         ki_r       <= '0;
         kd_r       <= '0;
         e          <= '0;
         i_new      <= '0;
         d          <= '0;
         i_acc      <= '0;
         e_prev     <= '0;
         acc        <= '0;
         resultado  <= '0;
         listo      <= 1'b0;
         sobrecarga <= 1'b0;
      end else begin
         listo <= 1'b0;
         case (estado)
            REPOSO: begin
               if (datolisto) begin
                  yk_r  <= yk;
                  ref_r <= referencia;
                  kp_r  <= kp;
                  ki_r  <= ki;
                  kd_r  <= kd;
               end else if (limpiar) begin
                  i_acc      <= '0;
                  e_prev     <= '0;
                  sobrecarga <= 1'b0;
               end
            end
            CARGA: begin
               e     <= e_sat;
               i_new <= i_sat;
               d     <= d_sat;
            end
            MI:         acc <= prod_sat;
            MD, ACUM:   acc <= acc + prod_sat;
            LISTO: begin
               resultado <= res_sat;
               listo     <= 1'b1;
               i_acc     <= i_new;
               e_prev    <= e;
            end
            default: ;
         endcase
         // A sample arriving mid-step is dropped but remembered.
         if (datolisto && ocupado) sobrecarga <= 1'b1;
      end
   end

endmodule

// File: tb/tb_planificador_pid_mac.sv
// Directed bench for planificador_pid_mac (N=16, F=8).
module tb_planificador_pid_mac;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic               datolisto = 1'b0;
   logic               limpiar = 1'b0;
   logic signed [15:0] yk = '0, rf = '0, kp = '0, ki = '0, kd = '0;
   logic signed [15:0] resultado;
   logic               listo, ocupado, sobrecarga;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   planificador_pid_mac #(.N(16), .F(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .datolisto  (datolisto),
      .yk         (yk),
      .referencia (rf),
      .kp         (kp),
      .ki         (ki),
      .kd         (kd),
      .limpiar    (limpiar),
      .resultado  (resultado),
      .listo      (listo),
      .ocupado    (ocupado),
      .sobrecarga (sobrecarga)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Pulse datolisto at a negedge, then wait for listo; leaves the bench on the listo cycle.
   task automatic paso(input logic [15:0] r, input logic [15:0] y, input logic [15:0] p,
                       input logic [15:0] i, input logic [15:0] dd, input logic [15:0] exp,
                       input string tag);
      int cyc;
      int ocu;
      rf = r; yk = y; kp = p; ki = i; kd = dd; datolisto = 1'b1;
      @(negedge clk);
      datolisto = 1'b0;
      cyc = 1;
      ocu = 0;
      while (!listo && cyc < 20) begin
         if (ocupado) ocu++;
         @(negedge clk);
         cyc++;
      end
      chk({tag, " latency"}, cyc, 7);
      chk({tag, " ocupado"}, ocu, 6);
      chk({tag, " resultado"}, {16'h0, resultado}, {16'h0, exp});
   endtask

   task automatic borrar();
      limpiar = 1'b1;
      @(negedge clk);
      limpiar = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      repeat (3) @(negedge clk);
      chk("rst resultado", {16'h0, resultado}, 32'h0);
      chk("rst listo", {31'h0, listo}, 32'h0);
      chk("rst ocupado", {31'h0, ocupado}, 32'h0);
      chk("rst sobrecarga", {31'h0, sobrecarga}, 32'h0);
      reset = 1'b1;
      @(negedge clk);

      // Proportional only
      paso(16'h0200, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0100, "prop");
      @(negedge clk);
      chk("prop listo pulse", {31'h0, listo}, 32'h0);
      borrar();

      // Integral, back-to-back
      paso(16'h0100, 16'h0000, 16'h0000, 16'h0080, 16'h0000, 16'h0080, "int1");
      paso(16'h0100, 16'h0000, 16'h0000, 16'h0080, 16'h0000, 16'h0100, "int2");
      paso(16'h0100, 16'h0000, 16'h0000, 16'h0080, 16'h0000, 16'h0180, "int3");
      chk("int sobrecarga", {31'h0, sobrecarga}, 32'h0);
      borrar();

      // Derivative
      paso(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000, "der1");
      paso(16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0100, "der2");
      paso(16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000, "der3");
      borrar();
      paso(16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0100, "der4");

      // Saturation
      paso(16'h7FFF, 16'h8000, 16'h0200, 16'h0000, 16'h0000, 16'h7FFF, "satpos");
      paso(16'h8000, 16'h7FFF, 16'h0200, 16'h0000, 16'h0000, 16'h8000, "satneg");
      borrar();

      // Overrun: second strobe two cycles after acceptance
      rf = 16'h0100; yk = 16'h0000; kp = 16'h0100; ki = 16'h0000; kd = 16'h0000;
      datolisto = 1'b1;
      @(negedge clk);
      datolisto = 1'b0;
      @(negedge clk);
      datolisto = 1'b1;
      rf = 16'h0300;
      @(negedge clk);
      datolisto = 1'b0;
      pulses = 0;
      repeat (12) begin
         if (listo) pulses++;
         @(negedge clk);
      end
      chk("ovr listo count", pulses, 1);
      chk("ovr resultado", {16'h0, resultado}, 32'h0100);
      chk("ovr sobrecarga", {31'h0, sobrecarga}, 32'h1);
      borrar();
      chk("ovr cleared", {31'h0, sobrecarga}, 32'h0);

      // Reset during MI after one integrating step
      paso(16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0100, "rstpre");
      datolisto = 1'b1;
      @(negedge clk);
      datolisto = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rstmid resultado", {16'h0, resultado}, 32'h0);
      chk("rstmid listo", {31'h0, listo}, 32'h0);
      chk("rstmid ocupado", {31'h0, ocupado}, 32'h0);
      chk("rstmid sobrecarga", {31'h0, sobrecarga}, 32'h0);
      pulses = 0;
      repeat (3) begin
         @(negedge clk);
         if (listo) pulses++;
      end
      reset = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (listo) pulses++;
      end
      chk("rstmid no listo", pulses, 0);
      paso(16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0100, "rstpost");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
